// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates redirect requests, holds the winner
// across stalls and runs a flush window after exceptions.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             excReq,
  input  logic             eretReq,
  input  logic             branchReq,
  input  logic             jumpImmReq,
  input  logic             jumpRegReq,
  input  logic [31:0]      epcIn,
  input  logic [31:0]      branchImmIn,
  input  logic [25:0]      jumpImmIn,
  input  logic [31:0]      jumpRegIn,
  output logic             pcEn,
  output logic             takeException,
  output logic             takeEret,
  output logic             takeBranch,
  output logic             takeJumpImm,
  output logic             takeJumpReg,
  output logic [31:0]      epc,
  output logic [31:0]      branchImmEx,
  output logic [25:0]      jumpImm,
  output logic [31:0]      jumpReg,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] redirectCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH
  } state_e;

  localparam int EXC  = 4;
  localparam int ERET = 3;
  localparam int BR   = 2;
  localparam int JIMM = 1;
  localparam int JREG = 0;

  localparam logic [4:0]       EXC_OH   = 5'b10000;
  localparam logic [3:0]       FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [3:0]       F_ONE    = 4'd1;
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  state_e           r_state;
  logic [4:0]       r_take;
  logic [3:0]       r_fcnt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_epc;
  logic [31:0]      r_br;
  logic [25:0]      r_jimm;
  logic [31:0]      r_jreg;

  logic [4:0]       w_win;
  logic             w_any;
  logic             w_cap;

  // fixed priority: exception > eret > branch > jumpImm > jumpReg
  always_comb begin
    w_win = '0;
    if (excReq)
      w_win[EXC] = 1'b1;
    else if (eretReq)
      w_win[ERET] = 1'b1;
    else if (branchReq)
      w_win[BR] = 1'b1;
    else if (jumpImmReq)
      w_win[JIMM] = 1'b1;
    else if (jumpRegReq)
      w_win[JREG] = 1'b1;
  end

  assign w_any = |w_win;

  assign w_cap = w_any &
    ((r_state == S_IDLE) |
     ((r_state == S_ISSUE) & ~stall & ~r_take[EXC]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_take  <= '0;
      r_fcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_take  <= w_win;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (stall) begin
            if (excReq && !r_take[EXC])
              r_take <= EXC_OH;
          end else begin
            if (r_cnt != '1)
              r_cnt <= r_cnt + C_ONE;
            if (r_take[EXC]) begin
              r_take  <= '0;
              r_fcnt  <= FLUSH_LD;
              r_state <= S_FLUSH;
            end else if (w_any) begin
              r_take <= w_win;
            end else begin
              r_take  <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (excReq) begin
            r_take  <= EXC_OH;
            r_state <= S_ISSUE;
          end else begin
            r_fcnt <= r_fcnt - F_ONE;
            if (r_fcnt <= F_ONE)
              r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_take  <= '0;
        end
      endcase
    end
  end

  // only the winner's operand moves; the others keep their last value
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_epc  <= '0;
      r_br   <= '0;
      r_jimm <= '0;
      r_jreg <= '0;
    end else if (w_cap) begin
      if (w_win[ERET])
        r_epc <= epcIn;
      if (w_win[BR])
        r_br <= branchImmIn;
      if (w_win[JIMM])
        r_jimm <= jumpImmIn;
      if (w_win[JREG])
        r_jreg <= jumpRegIn;
    end
  end

  assign pcEn          = rst & ~stall;
  assign takeException = r_take[EXC];
  assign takeEret      = r_take[ERET];
  assign takeBranch    = r_take[BR];
  assign takeJumpImm   = r_take[JIMM];
  assign takeJumpReg   = r_take[JREG];
  assign epc           = r_epc;
  assign branchImmEx   = r_br;
  assign jumpImm       = r_jimm;
  assign jumpReg       = r_jreg;
  assign busy          = (r_state != S_IDLE);
  assign flush         = (r_state == S_FLUSH) |
                         ((|r_take) & ~stall);
  assign redirectCount = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_pc_redirect_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, stall;
  logic excReq, eretReq, branchReq;
  logic jumpImmReq, jumpRegReq;
  logic [31:0] epcIn, branchImmIn, jumpRegIn;
  logic [25:0] jumpImmIn;
  logic pcEn;
  logic takeException, takeEret, takeBranch;
  logic takeJumpImm, takeJumpReg;
  logic [31:0] epc, branchImmEx, jumpReg;
  logic [25:0] jumpImm;
  logic flush, busy;
  logic [CW-1:0] redirectCount;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .FLUSH_CYCLES(FC),
    .CNT_W(CW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .excReq(excReq),
    .eretReq(eretReq),
    .branchReq(branchReq),
    .jumpImmReq(jumpImmReq),
    .jumpRegReq(jumpRegReq),
    .epcIn(epcIn),
    .branchImmIn(branchImmIn),
    .jumpImmIn(jumpImmIn),
    .jumpRegIn(jumpRegIn),
    .pcEn(pcEn),
    .takeException(takeException),
    .takeEret(takeEret),
    .takeBranch(takeBranch),
    .takeJumpImm(takeJumpImm),
    .takeJumpReg(takeJumpReg),
    .epc(epc),
    .branchImmEx(branchImmEx),
    .jumpImm(jumpImm),
    .jumpReg(jumpReg),
    .flush(flush),
    .busy(busy),
    .redirectCount(redirectCount)
  );

  int n_chk = 0;
  int n_fail = 0;
  int flush_seen = 0;
  int br_seen = 0;

  // model: kind 0 none, 1 exc, 2 eret, 3 branch, 4 jimm, 5 jreg
  int m_kind, m_fl, m_cnt;
  logic [31:0] m_epc, m_br, m_jr;
  logic [25:0] m_ji;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic drv(input logic r, input logic s,
                     input logic e, input logic er,
                     input logic b, input logic ji,
                     input logic jr);
    rst = r; stall = s; excReq = e; eretReq = er;
    branchReq = b; jumpImmReq = ji; jumpRegReq = jr;
  endtask

  task automatic grab(input int w);
    m_kind = w;
    case (w)
      2: m_epc = epcIn;
      3: m_br = branchImmIn;
      4: m_ji = jumpImmIn;
      5: m_jr = jumpRegIn;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int w;
    w = excReq ? 1 : eretReq ? 2 : branchReq ? 3 :
        jumpImmReq ? 4 : jumpRegReq ? 5 : 0;
    if (!rst) begin
      m_kind = 0; m_fl = 0; m_cnt = 0;
      m_epc = '0; m_br = '0; m_ji = '0; m_jr = '0;
    end else if (m_kind != 0) begin
      if (stall) begin
        if (excReq) m_kind = 1;
      end else begin
        if (m_cnt < CMAX) m_cnt++;
        if (m_kind == 1) begin
          m_kind = 0;
          m_fl = FC;
        end else begin
          m_kind = 0;
          grab(w);
        end
      end
    end else if (m_fl > 0) begin
      if (excReq) begin
        m_kind = 1;
        m_fl = 0;
      end else begin
        m_fl--;
      end
    end else begin
      grab(w);
    end
  endtask

  task automatic compare_all();
    logic [4:0] et;
    logic ef;
    et = (m_kind == 0) ? 5'd0 : 5'd1 << (5 - m_kind);
    ef = (m_fl > 0) || (m_kind != 0 && !stall);
    chk("take", {27'd0, takeException, takeEret, takeBranch,
                 takeJumpImm, takeJumpReg}, {27'd0, et});
    chk("epc", epc, m_epc);
    chk("brimm", branchImmEx, m_br);
    chk("jimm", {6'd0, jumpImm}, {6'd0, m_ji});
    chk("jreg", jumpReg, m_jr);
    chk("flush", {31'd0, flush}, {31'd0, ef});
    chk("busy", {31'd0, busy},
        {31'd0, (m_kind != 0 || m_fl > 0)});
    chk("pcen", {31'd0, pcEn}, {31'd0, rst & ~stall});
    chk("cnt", {28'd0, redirectCount}, m_cnt[31:0]);
    if (flush === 1'b1) flush_seen++;
    if (takeBranch === 1'b1) br_seen++;
  endtask

  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
  endtask

  initial begin
    epcIn = '0; branchImmIn = '0;
    jumpImmIn = '0; jumpRegIn = '0;
    drv(0, 0, 0, 0, 0, 0, 0);
    m_kind = 0; m_fl = 0; m_cnt = 0;
    m_epc = '0; m_br = '0; m_ji = '0; m_jr = '0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // reset release, no requests
    drv(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pcen", {31'd0, pcEn}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {28'd0, redirectCount}, 32'd0);
    chk("rst_take", {27'd0, takeException, takeEret,
        takeBranch, takeJumpImm, takeJumpReg}, 32'd0);
    step();

    // priority: only the exception issues
    flush_seen = 0; br_seen = 0;
    drv(1, 0, 1, 1, 1, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 0, 0);
    #1 chk("prio_exc", {31'd0, takeException}, 32'd1);
    repeat (6) step();
    chk("prio_flush", flush_seen, FC + 1);
    chk("prio_nobr", br_seen, 32'd0);
    chk("prio_cnt", {28'd0, redirectCount}, 32'd1);

    // stall hold
    do_reset();
    branchImmIn = 32'h0000_1234;
    drv(1, 0, 0, 0, 1, 0, 0);
    step();
    branchImmIn = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 0, 0, 0, 0);
      #1;
      chk("hold_br", {31'd0, takeBranch}, 32'd1);
      chk("hold_imm", branchImmEx, 32'h0000_1234);
      chk("hold_pcen", {31'd0, pcEn}, 32'd0);
      step();
    end
    drv(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("hold_drop", {31'd0, takeBranch}, 32'd0);
    chk("hold_cnt", {28'd0, redirectCount}, 32'd1);

    // preemption of a held register jump
    do_reset();
    jumpRegIn = 32'h2222_2220;
    drv(1, 1, 0, 0, 0, 0, 1);
    step();
    drv(1, 1, 1, 0, 0, 0, 0);
    #1 chk("pre_jr", {31'd0, takeJumpReg}, 32'd1);
    step();
    chk("pre_exc", {31'd0, takeException}, 32'd1);
    chk("pre_nojr", {31'd0, takeJumpReg}, 32'd0);
    drv(1, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("pre_cnt", {28'd0, redirectCount}, 32'd1);

    // back-to-back jumpImm then eret
    do_reset();
    jumpImmIn = 26'h123_4567;
    epcIn = 32'h1111_1110;
    drv(1, 0, 0, 0, 0, 1, 0);
    step();
    drv(1, 0, 0, 1, 0, 0, 0);
    #1 chk("b2b_ji", {31'd0, takeJumpImm}, 32'd1);
    step();
    chk("b2b_eret", {31'd0, takeEret}, 32'd1);
    chk("b2b_noji", {31'd0, takeJumpImm}, 32'd0);
    chk("b2b_epc", epc, 32'h1111_1110);
    drv(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("b2b_idle", {31'd0, takeEret}, 32'd0);
    chk("b2b_cnt", {28'd0, redirectCount}, 32'd2);
    chk("b2b_jimm", {6'd0, jumpImm}, 32'h0123_4567);

    // branch during flush window is dropped
    do_reset();
    br_seen = 0;
    drv(1, 0, 1, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 1, 0, 0);
    repeat (FC) step();
    drv(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("flt_nobr", br_seen, 32'd0);

    // saturation
    do_reset();
    drv(1, 0, 0, 0, 1, 0, 0);
    repeat (20) step();
    chk("sat_cnt", {28'd0, redirectCount}, 32'hF);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      epcIn = $urandom;
      branchImmIn = $urandom;
      jumpImmIn = 26'($urandom);
      jumpRegIn = $urandom;
      drv(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequencer in front of the PC register that turns raw redirect requests from the pipeline into the one-hot takeException/takeEret/takeBranch/takeJumpImm/takeJumpReg strobes and operand buses the PC consumes. It arbitrates simultaneous requests by fixed priority and holds a granted redirect stable across fetch stalls. After an exception it runs a post-exception flush window. It also drives the PC write enable and a redirect counter.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after an exception is applied (1..15)
CNT_W, 16, width of redirectCount

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
stall  in  1  fetch/hazard stall; PC must not update while high
excReq  in  1  exception request
eretReq  in  1  ERET request
branchReq  in  1  taken-branch request
jumpImmReq  in  1  J/JAL request
jumpRegReq  in  1  JR/JALR request
epcIn  in  32  return address for ERET
branchImmIn  in  32  sign-extended branch offset (words)
jumpImmIn  in  26  J-type index
jumpRegIn  in  32  register jump target
pcEn  out  1  PC write enable
takeException, takeEret, takeBranch, takeJumpImm, takeJumpReg  out  1 each  one-hot redirect select to PC
epc  out  32  held ERET target
branchImmEx  out  32  held branch offset
jumpImm  out  26  held jump index
jumpReg  out  32  held register target
flush  out  1  squash younger pipeline stages
busy  out  1  redirect pending or flush window active
redirectCount  out  CNT_W  number of redirects applied, saturating

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE; all take* = 0; all operand outputs = 0; flush = 0; busy = 0; redirectCount = 0; pcEn = 0 while rst is low.
- pcEn = rst & ~stall (combinational). The PC advances to pc4 whenever pcEn is high and no take* is high.
- Priority, highest first: exception > eret > branch > jumpImm > jumpReg. Only the winner is captured; losers in the same cycle are dropped and not queued.
- States: IDLE, ISSUE, FLUSH.
- IDLE: if any request is high at the edge, register the winner's take* and its operand, and go to ISSUE. Operand outputs of non-winners keep their previous values. Latency is one cycle from request to strobe.
- ISSUE: the take* strobe and operand stay stable while stall is high; busy = 1.
  - At an edge with stall=0 the redirect is applied by the PC (pcEn is high). Clear take* and increment redirectCount (saturates at all-ones).
  - If the applied redirect was an exception, load the flush counter with FLUSH_CYCLES and go to FLUSH. Otherwise go to IDLE, or capture a new request at that same edge if one is present (back-to-back redirects are allowed).
- ISSUE preemption: excReq while a non-exception redirect is held replaces it, with takeException and its effect starting next cycle. Any other request during ISSUE is ignored.
- FLUSH: flush = 1 and busy = 1. The counter decrements on every edge, including stalled ones. branch, jumpImm, jumpReg and eret requests are ignored. excReq recaptures into ISSUE immediately. Return to IDLE when the counter reaches 0; flush drops in the same cycle.
- flush is also high during the cycle any take* is high and stall=0, so the wrong-path fetch is squashed.
- busy = (state != IDLE).
- Reset mid-operation: an active reset discards any held redirect and aborts the flush window, returning to the reset values listed above.
- No combinational path from req* to take*. pcEn depends on stall only.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 with no requests -> all take*=0, pcEn=1, redirectCount=0, busy=0.
- Priority: excReq=eretReq=branchReq=1 for one cycle -> next cycle only takeException=1. flush=1 for FLUSH_CYCLES+1 cycles in total (the apply cycle plus the FLUSH window). The branch is never issued. redirectCount=1.
- Stall hold: branchReq=1 with branchImmIn=32'h0000_1234, then stall=1 for 3 cycles -> takeBranch=1 and branchImmEx=32'h0000_1234 stay stable and pcEn=0 for those 3 cycles. takeBranch drops one cycle after stall falls. redirectCount=1.
- Preemption: jumpRegReq=1 (jumpRegIn=32'h2222_2220) with stall=1, then excReq=1 -> takeJumpReg is replaced by takeException. The jump is never applied.
- Back-to-back: jumpImmReq (jumpImmIn=26'h123_4567), then eretReq (epcIn=32'h1111_1110) one cycle later with stall=0 -> takeJumpImm for 1 cycle followed by takeEret for 1 cycle. redirectCount=2.
- Flush filtering and saturation: branchReq during FLUSH -> ignored, no strobe. Force redirectCount to all-ones via repeated requests at CNT_W=4 -> the count holds at 4'hF.
